// File: rtl/order_pkg.sv
// Shared types and widths for the order manager.
package order_pkg;

    localparam int PRICE_W = 8;
    localparam int ID_W    = 8;
    localparam int QTY_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COOL
    } state_t;

    typedef enum logic {
        BUY  = 1'b0,
        SELL = 1'b1
    } side_t;

    typedef struct packed {
        side_t              side;
        logic [QTY_W-1:0]   qty;
        logic [PRICE_W-1:0] price;
        logic [ID_W-1:0]    id;
    } order_t;

    // Saturating add of a small increment onto an 8-bit counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, inc};
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Single rising-edge detector; history flop clears on synchronous active-low reset.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic hist_q, hist_d;

    always_comb hist_d = sig_in;

    always_ff @(posedge clk) begin
        if (!rst) hist_q <= 1'b0;
        else      hist_q <= hist_d;
    end

    assign rise = sig_in & ~hist_q;

endmodule

// File: rtl/order_manager.sv
// Turns buy/sell signal edges into single gateway orders with position limit and cooldown.
// Optional macro ORDER_TIMEOUT_EN withdraws an order left unaccepted for TIMEOUT cycles.
module order_manager
    import order_pkg::*;
#(
    parameter logic [QTY_W-1:0]        ORDER_QTY = 4'd1,
    parameter int                      POS_W     = 8,
    parameter logic signed [POS_W-1:0] MAX_POS   = 8'sd4,
    parameter logic [7:0]              COOLDOWN  = 8'd8,
    parameter logic [7:0]              TIMEOUT   = 8'd16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    buy_signal,
    input  logic                    sell_signal,
    input  logic [PRICE_W-1:0]      price_in,
    output logic                    order_valid,
    input  logic                    order_ready,
    output logic                    order_side,
    output logic [QTY_W-1:0]        order_qty,
    output logic [PRICE_W-1:0]      order_price,
    output logic [ID_W-1:0]         order_id,
    output logic signed [POS_W-1:0] position,
    output logic [7:0]              drop_count
);

    // One guard bit so the limit comparisons cannot overflow.
    localparam logic signed [POS_W:0]   QTY_S = $signed({{(POS_W+1-QTY_W){1'b0}}, ORDER_QTY});
    localparam logic signed [POS_W:0]   MAX_S = $signed({MAX_POS[POS_W-1], MAX_POS});
    localparam logic signed [POS_W-1:0] QTY_P = QTY_S[POS_W-1:0];

    state_t                    state_q, state_d;
    order_t                    ord_q, ord_d;
    logic signed [POS_W-1:0]   pos_q, pos_d;
    logic [7:0]                drop_q, drop_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [1:0]                drop_inc;
    logic                      buy_rise, sell_rise, any_rise;
    logic signed [POS_W:0]     pos_ext;
    logic                      buy_ok, sell_ok;

    edge_detect u_buy_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (buy_signal),
        .rise   (buy_rise)
    );

    edge_detect u_sell_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sell_signal),
        .rise   (sell_rise)
    );

    assign any_rise = buy_rise | sell_rise;
    assign pos_ext  = {pos_q[POS_W-1], pos_q};
    assign buy_ok   = (pos_ext + QTY_S) <= MAX_S;
    assign sell_ok  = (pos_ext - QTY_S) >= -MAX_S;

`ifdef ORDER_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    always_comb wait_d = (state_q == ISSUE) ? wait_q + 8'd1 : 8'd0;

    always_ff @(posedge clk) begin
        if (!rst) wait_q <= 8'd0;
        else      wait_q <= wait_d;
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

    always_comb begin
        state_d  = state_q;
        ord_d    = ord_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        drop_inc = 2'd0;
        case (state_q)
            IDLE: begin
                if (any_rise) begin
                    if ((buy_rise && sell_rise) || !enable) begin
                        drop_inc = 2'd1;
                    end else if (buy_rise && buy_ok) begin
                        ord_d.side  = BUY;
                        ord_d.price = price_in;
                        state_d     = ISSUE;
                    end else if (sell_rise && sell_ok) begin
                        ord_d.side  = SELL;
                        ord_d.price = price_in;
                        state_d     = ISSUE;
                    end else begin
                        drop_inc = 2'd1;
                    end
                end
            end
            ISSUE: begin
                if (any_rise) drop_inc = 2'd1;
                if (order_ready) begin
                    pos_d    = (ord_q.side == SELL) ? pos_q - QTY_P : pos_q + QTY_P;
                    ord_d.id = ord_q.id + 8'd1;
                    state_d  = (COOLDOWN == 8'd0) ? IDLE : COOL;
                    cnt_d    = COOLDOWN;
                end
`ifdef ORDER_TIMEOUT_EN
                else if (wait_q == TIMEOUT - 8'd1) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = (COOLDOWN == 8'd0) ? IDLE : COOL;
                    cnt_d    = COOLDOWN;
                end
`endif
            end
            COOL: begin
                if (any_rise) drop_inc = 2'd1;
                if (cnt_q == 8'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
        drop_d = sat_add8(drop_q, drop_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ord_q   <= '{side: BUY, qty: ORDER_QTY, price: '0, id: '0};
            pos_q   <= '0;
            drop_q  <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ord_q   <= ord_d;
            pos_q   <= pos_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign order_valid = (state_q == ISSUE);
    assign order_side  = ord_q.side;
    assign order_qty   = ord_q.qty;
    assign order_price = ord_q.price;
    assign order_id    = ord_q.id;
    assign position    = pos_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_order_manager.sv
// Scoreboard bench for order_manager: randomized and directed stimulus against a reference model.
module tb_order_manager;

    localparam int QTY  = 1;
    localparam int MAXP = 4;
    localparam int CD   = 8;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        buy_signal = 1'b0;
    logic        sell_signal = 1'b0;
    logic [7:0]  price_in = 8'd0;
    logic        order_ready = 1'b0;
    logic        order_valid;
    logic        order_side;
    logic [3:0]  order_qty;
    logic [7:0]  order_price;
    logic [7:0]  order_id;
    logic signed [7:0] position;
    logic [7:0]  drop_count;

    order_manager dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .buy_signal  (buy_signal),
        .sell_signal (sell_signal),
        .price_in    (price_in),
        .order_valid (order_valid),
        .order_ready (order_ready),
        .order_side  (order_side),
        .order_qty   (order_qty),
        .order_price (order_price),
        .order_id    (order_id),
        .position    (position),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int side;
        int price;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase 0 = free, 1 = order outstanding, 2 = cooling down.
    int m_pos, m_drop, m_id, m_phase, m_cool, m_wait, m_side;
    bit m_pb, m_ps;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void drop1();
        if (m_drop < 255) m_drop++;
    endfunction

    function automatic void enter_cool();
        if (CD == 0) m_phase = 0;
        else begin
            m_phase = 2;
            m_cool  = CD;
        end
    endfunction

    function automatic void issue(input int side, input int p);
        exp_t e;
        e.side = side;
        e.price = p;
        e.id = m_id;
        exp_q.push_back(e);
        m_side  = side;
        m_phase = 1;
        m_wait  = 0;
    endfunction

    // Apply one cycle of inputs, advance the model, then let the DUT clock.
    task automatic step(input bit b, input bit s, input bit en, input bit rdy,
                        input int p, input bit r = 1'b1);
        bit rb, rs;
        rst = r; buy_signal = b; sell_signal = s; enable = en;
        order_ready = rdy; price_in = 8'(p);
        if (!r) begin
            m_pos = 0; m_drop = 0; m_id = 0; m_phase = 0;
            m_cool = 0; m_wait = 0; m_pb = 0; m_ps = 0;
        end else begin
            rb = b && !m_pb;
            rs = s && !m_ps;
            m_pb = b;
            m_ps = s;
            if (m_phase == 0) begin
                if (rb || rs) begin
                    if ((rb && rs) || !en)               drop1();
                    else if (rb && m_pos + QTY <= MAXP)  issue(0, p);
                    else if (rs && m_pos - QTY >= -MAXP) issue(1, p);
                    else                                 drop1();
                end
            end else if (m_phase == 1) begin
                if (rb || rs) drop1();
                if (rdy) begin
                    m_pos += (m_side == 1) ? -QTY : QTY;
                    m_id = (m_id + 1) % 256;
                    enter_cool();
                end else begin
                    m_wait++;
`ifdef ORDER_TIMEOUT_EN
                    if (m_wait == TO) begin
                        drop1();
                        enter_cool();
                    end
`endif
                end
            end else begin
                if (rb || rs) drop1();
                if (m_cool == 0) m_phase = 0;
                else m_cool--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state();
        chk("position", int'(position), m_pos);
        chk("drop_count", int'(drop_count), m_drop);
        chk("order_valid", int'(order_valid), (m_phase == 1) ? 1 : 0);
    endtask

    // Monitor: every presented order must match the oldest expected one; an order
    // retires when order_valid falls (handshake, withdrawal or reset).
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if (order_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_order", 1, 0);
            end else begin
                chk("order_side", int'(order_side), exp_q[0].side);
                chk("order_price", int'(order_price), exp_q[0].price);
                chk("order_id", int'(order_id), exp_q[0].id);
                chk("order_qty", int'(order_qty), QTY);
            end
        end else if (prev_v && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        prev_v = order_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit b, s;

        // Reset state and first order with latency, fields and cooldown.
        repeat (3) step(0, 0, 1, 1, 0, 0);
        check_state();
        chk("reset_id", int'(order_id), 0);
        chk("reset_price", int'(order_price), 0);
        chk("reset_side", int'(order_side), 0);
        step(1, 0, 1, 1, 100);
        chk("first_valid", int'(order_valid), 1);
        step(1, 0, 1, 1, 100);
        chk("first_pos", int'(position), 1);
        // Buy held high: edge only.
        repeat (20) begin
            step(1, 0, 1, 1, 100);
            check_state();
        end
        chk("held_drop", int'(drop_count), 0);
        chk("held_id", int'(order_id), 1);

        // Position limit: fifth buy edge dropped.
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 1, 10 + i);
            repeat (11) step(0, 0, 1, 1, 0);
            check_state();
        end
        chk("limit_pos", int'(position), 4);
        chk("limit_drop", int'(drop_count), 1);

        // Conflict, rise while busy, fields held under back-pressure.
        step(0, 0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 50);
        chk("conflict_drop", int'(drop_count), 1);
        chk("conflict_valid", int'(order_valid), 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 77);
        step(0, 0, 0, 0, 78);
        step(0, 1, 0, 0, 99);
        repeat (4) begin
            step(0, 1, 1, 0, 99);
            check_state();
        end
        chk("busy_drop", int'(drop_count), 2);
        step(0, 0, 1, 1, 0);
        check_state();
        chk("sell_pos", int'(position), -1);

        // Rise during cooldown is discarded.
        step(1, 0, 1, 1, 3);
        check_state();

        // id wrap with alternating sides.
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 256; i++) begin
            step(i % 2 == 0, i % 2 == 1, 1, 1, i);
            step(0, 0, 1, 1, 0);
            check_state();
            repeat (10) step(0, 0, 1, 1, 0);
        end
        chk("wrap_id", int'(order_id), 0);
        chk("wrap_pos", int'(position), 0);

        // Reset while an order is waiting.
        step(1, 0, 1, 0, 5);
        step(0, 0, 1, 0, 5);
        chk("pre_reset_pos", int'(position), 0);
        step(0, 0, 1, 0, 5, 0);
        chk("reset_valid", int'(order_valid), 0);
        chk("reset_pos", int'(position), 0);
        check_state();

`ifdef ORDER_TIMEOUT_EN
        step(1, 0, 1, 0, 9);
        repeat (TO) step(0, 0, 1, 0, 9);
        chk("timeout_valid", int'(order_valid), 0);
        chk("timeout_pos", int'(position), 0);
        chk("timeout_drop", int'(drop_count), 1);
        repeat (12) step(0, 0, 1, 1, 0);
`endif

        // Random traffic.
        b = 0;
        s = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) b = ~b;
            if ($urandom_range(0, 7) == 0) s = ~s;
            step(b, s, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                 int'($urandom_range(0, 255)));
            check_state();
        end

        repeat (40) step(0, 0, 1, 1, 0);
        check_state();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
